// File: rtl/j_snd_pkg.sv
// j_snd_pkg: shared widths and stereo frame type for the sound output buffer.
package j_snd_pkg;
    localparam int SND_W = 16;
    localparam int FRAME_W = 2 * SND_W;
    typedef struct packed {
        logic [SND_W-1:0] l;
        logic [SND_W-1:0] r;
    } snd_frame_t;
endpackage

// File: rtl/j_snd_fifo_ram.sv
// j_snd_fifo_ram: 2**AW x FRAME_W register file, one write port, registered read.
// The read register doubles as the audio output register; clr_i zeroes it for mute.
module j_snd_fifo_ram
    import j_snd_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  snd_frame_t    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          clr_i,
    output snd_frame_t    rdata_o
);
    logic [FRAME_W-1:0] mem_q [2**AW];
    snd_frame_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (clr_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/j_snd_out_buf.sv
// j_snd_out_buf: pairs L/R DAC writes into frames, queues them, releases one per smp_tick.
// Optional J_SND_UDF_MUTE_EN: mute outputs after MUTE_TICKS consecutive underrun ticks.
module j_snd_out_buf
    import j_snd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
`ifdef J_SND_UDF_MUTE_EN
    , parameter int MUTE_TICKS = 256
`endif
) (
    input  logic                  sys_clk,
    input  logic                  resetl,
    input  logic [SND_W-1:0]      snd_l,
    input  logic [SND_W-1:0]      snd_r,
    input  logic                  snd_l_en,
    input  logic                  snd_r_en,
    input  logic                  smp_tick,
    input  logic                  clr_flags,
    output logic [SND_W-1:0]      aud_l,
    output logic [SND_W-1:0]      aud_r,
    output logic                  aud_valid,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  ovf,
    output logic                  udf
);
    logic en_l_q, en_r_q, pend_l_q, pend_r_q, pend_l_d, pend_r_d;
    logic ovf_q, ovf_d, udf_q, udf_d, aud_valid_q;
    logic cap_l, cap_r, push, pop, udf_ev, full, wr_en, mute_clr;
    snd_frame_t hold_q, hold_d, rdata;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] fill_q, fill_d;

    always_comb begin
        cap_l = en_l_q & ~snd_l_en;
        cap_r = en_r_q & ~snd_r_en;
        push = pend_l_q & pend_r_q;
        pop = smp_tick & (fill_q != '0);
        udf_ev = smp_tick & (fill_q == '0);
        full = fill_q[DEPTH_LOG2];
        wr_en = push & (~full | pop);
        hold_d.l = cap_l ? snd_l : hold_q.l;
        hold_d.r = cap_r ? snd_r : hold_q.r;
        // a capture in the push cycle starts the next frame
        pend_l_d = cap_l | (pend_l_q & ~push);
        pend_r_d = cap_r | (pend_r_q & ~push);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d = (wr_en & ~pop) ? fill_q + 1'b1 : (pop & ~wr_en) ? fill_q - 1'b1 : fill_q;
        ovf_d = (push & full & ~pop) | (ovf_q & ~clr_flags);
        udf_d = udf_ev | (udf_q & ~clr_flags);
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            en_l_q <= 1'b0;
            en_r_q <= 1'b0;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            hold_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            aud_valid_q <= 1'b0;
        end else begin
            en_l_q <= snd_l_en;
            en_r_q <= snd_r_en;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            hold_q <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q <= fill_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            aud_valid_q <= pop;
        end
    end

`ifdef J_SND_UDF_MUTE_EN
    localparam int CW = $clog2(MUTE_TICKS + 1);
    logic [CW-1:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        udf_cnt_d = pop ? '0 : (udf_ev && udf_cnt_q != CW'(MUTE_TICKS)) ? udf_cnt_q + 1'b1 : udf_cnt_q;
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) udf_cnt_q <= '0;
        else udf_cnt_q <= udf_cnt_d;
    end

    // the tick that brings the run to MUTE_TICKS zeroes the output until a pop reloads it
    assign mute_clr = udf_ev & (udf_cnt_q >= CW'(MUTE_TICKS - 1));
`else
    assign mute_clr = 1'b0;
`endif

    j_snd_fifo_ram #(.AW(DEPTH_LOG2)) u_ram (
        .clk     (sys_clk),
        .rst_n   (resetl),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (hold_q),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .clr_i   (mute_clr),
        .rdata_o (rdata)
    );

    assign aud_l = rdata.l;
    assign aud_r = rdata.r;
    assign aud_valid = aud_valid_q;
    assign fill = fill_q;
    assign ovf = ovf_q;
    assign udf = udf_q;
endmodule

// File: tb/tb_j_snd_out_buf.sv
// tb_j_snd_out_buf: table-driven pairing vectors plus overflow/underrun/mute/reset sequences.
// Popped frames are checked against a scoreboard queue filled as frames are written.
module tb_j_snd_out_buf;
    logic sys_clk = 1'b0, resetl = 1'b0;
    logic [15:0] snd_l = '0, snd_r = '0;
    logic snd_l_en = 1'b0, snd_r_en = 1'b0, smp_tick = 1'b0, clr_flags = 1'b0;
    logic [15:0] aud_l, aud_r;
    logic aud_valid, ovf, udf;
    logic [4:0] fill;
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

`ifdef J_SND_UDF_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    typedef struct {
        logic [15:0] l0;
        logic [15:0] l;
        logic [15:0] r;
        int          mode;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;
    vec_t vt[5];

    j_snd_out_buf #(
        .DEPTH_LOG2(4)
`ifdef J_SND_UDF_MUTE_EN
        , .MUTE_TICKS(4)
`endif
    ) dut (
        .sys_clk(sys_clk), .resetl(resetl), .snd_l(snd_l), .snd_r(snd_r),
        .snd_l_en(snd_l_en), .snd_r_en(snd_r_en), .smp_tick(smp_tick), .clr_flags(clr_flags),
        .aud_l(aud_l), .aud_r(aud_r), .aud_valid(aud_valid), .fill(fill), .ovf(ovf), .udf(udf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr_l(input logic [15:0] v, input int n);
        snd_l = v;
        snd_l_en = 1'b1;
        repeat (n) step();
        snd_l_en = 1'b0;
        step();
    endtask

    task automatic wr_r(input logic [15:0] v, input int n);
        snd_r = v;
        snd_r_en = 1'b1;
        repeat (n) step();
        snd_r_en = 1'b0;
        step();
    endtask

    task automatic wr_lr(input logic [15:0] l, input logic [15:0] r, input int n);
        snd_l = l;
        snd_r = r;
        snd_l_en = 1'b1;
        snd_r_en = 1'b1;
        repeat (n) step();
        snd_l_en = 1'b0;
        snd_r_en = 1'b0;
        step();
    endtask

    task automatic tick();
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
    endtask

    task automatic clr();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        if (resetl && aud_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h%h expected no output", aud_l, aud_r);
            end else begin
                mon_e = exp_q.pop_front();
                if ({aud_l, aud_r} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_frame: got %h%h expected %h", aud_l, aud_r, mon_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'h0000, 16'h1234, 16'hABCD, 0, 16'h1234, 16'hABCD};
        vt[1] = '{16'h0000, 16'h0001, 16'h0002, 1, 16'h0001, 16'h0002};
        vt[2] = '{16'h1111, 16'h2222, 16'h3333, 3, 16'h2222, 16'h3333};
        vt[3] = '{16'h0000, 16'h8000, 16'h7FFF, 2, 16'h8000, 16'h7FFF};
        vt[4] = '{16'h0000, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 16'h0000};
        repeat (3) step();
        resetl = 1'b1;
        step();
        chk("rst_fill", fill, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_valid", aud_valid, 0);
        chk("rst_aud", {aud_l, aud_r}, 0);

        for (int i = 0; i < 5; i++) begin
            case (vt[i].mode)
                0: begin wr_l(vt[i].l, 4); wr_r(vt[i].r, 4); end
                1: wr_lr(vt[i].l, vt[i].r, 2);
                2: begin wr_r(vt[i].r, 3); wr_l(vt[i].l, 3); end
                default: begin
                    wr_l(vt[i].l0, 4);
                    wr_l(vt[i].l, 4);
                    chk("ow_nopush", fill, 0);
                    wr_r(vt[i].r, 4);
                end
            endcase
            exp_q.push_back({vt[i].el, vt[i].er});
            chk("vec_fill_pre", fill, 0);
            step();
            chk("vec_fill_push", fill, 1);
            step();
            chk("vec_fill_hold", fill, 1);
            tick();
            chk("vec_aud_l", aud_l, vt[i].el);
            chk("vec_aud_r", aud_r, vt[i].er);
            chk("vec_valid", aud_valid, 1);
            chk("vec_fill_pop", fill, 0);
            step();
            chk("vec_valid_pulse", aud_valid, 0);
        end

        for (int n = 0; n < 17; n++) begin
            wr_lr(16'(n), ~16'(n), 1);
            if (n < 16) exp_q.push_back({16'(n), ~16'(n)});
            step();
            if (n == 15) begin
                chk("full_fill", fill, 16);
                chk("full_no_ovf", ovf, 0);
            end
        end
        chk("ovf_set", ovf, 1);
        chk("ovf_fill", fill, 16);
        clr();
        chk("ovf_clr", ovf, 0);
        snd_l = 16'hC0DE;
        snd_r = 16'hBEEF;
        snd_l_en = 1'b1;
        snd_r_en = 1'b1;
        step();
        snd_l_en = 1'b0;
        snd_r_en = 1'b0;
        step();
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        exp_q.push_back(32'hC0DE_BEEF);
        chk("full_pushpop_fill", fill, 16);
        chk("full_pushpop_ovf", ovf, 0);
        repeat (16) begin tick(); step(); end
        chk("drain_fill", fill, 0);

        wr_lr(16'h5555, 16'h0AAA, 1);
        exp_q.push_back(32'h5555_0AAA);
        step();
        tick();
        step();
        chk("udf_pre", udf, 0);
        tick();
        chk("udf_set", udf, 1);
        chk("udf_hold_l", aud_l, 16'h5555);
        chk("udf_no_valid", aud_valid, 0);
        clr();
        chk("udf_clr", udf, 0);
        smp_tick = 1'b1;
        clr_flags = 1'b1;
        step();
        smp_tick = 1'b0;
        clr_flags = 1'b0;
        chk("udf_set_wins", udf, 1);
        clr();
        wr_lr(16'h4444, 16'h4445, 1);
        tick();
        exp_q.push_back(32'h4444_4445);
        chk("nobypass_udf", udf, 1);
        chk("nobypass_valid", aud_valid, 0);
        chk("nobypass_fill", fill, 1);
        tick();
        chk("nobypass_pop", aud_l, 16'h4444);
        step();
        clr();

        wr_lr(16'h7FFF, 16'h7FFF, 1);
        exp_q.push_back(32'h7FFF_7FFF);
        step();
        tick();
        step();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("mute_l", aud_l, (MUTE && k == 4) ? 16'h0000 : 16'h7FFF);
            chk("mute_r", aud_r, (MUTE && k == 4) ? 16'h0000 : 16'h7FFF);
            step();
        end
        wr_lr(16'h1357, 16'h2468, 1);
        exp_q.push_back(32'h1357_2468);
        step();
        tick();
        chk("unmute", {aud_l, aud_r}, 32'h1357_2468);
        step();

        wr_lr(16'h9999, 16'h8888, 1);
        step();
        wr_l(16'hAAAA, 1);
        chk("mid_fill", fill, 1);
        #2 resetl = 1'b0;
        #1;
        chk("async_fill", fill, 0);
        chk("async_aud", {aud_l, aud_r}, 0);
        chk("async_flags", {ovf, udf, aud_valid}, 0);
        step();
        resetl = 1'b1;
        wr_r(16'hBBBB, 1);
        step();
        step();
        chk("rst_pend_clr", fill, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
